// File: rtl/time_entry_ctrl.sv
// Push-button time/date/alarm entry front end for main_driver.
// Edits a shadow copy seeded from the live clock, then commits it with a one-cycle set strobe.
module time_entry_ctrl #(
    parameter int YEAR_MIN       = 2000,
    parameter int YEAR_MAX       = 2099,
    parameter int TIMEOUT_CYCLES = 30
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [7:0]  cur_hour,
    input  logic [7:0]  cur_min,
    input  logic [7:0]  cur_sec,
    input  logic [7:0]  cur_day,
    input  logic [7:0]  cur_month,
    input  logic [15:0] cur_year,
    output logic [7:0]  input_hour,
    output logic [7:0]  input_min,
    output logic [7:0]  input_sec,
    output logic [7:0]  input_day,
    output logic [7:0]  input_month,
    output logic [15:0] input_year,
    output logic [7:0]  alarm_input_hour,
    output logic [7:0]  alarm_input_min,
    output logic [7:0]  alarm_input_sec,
    output logic        set_time,
    output logic        set_date,
    output logic        set_alarm,
    output logic        edit_active,
    output logic [1:0]  edit_group,
    output logic [1:0]  edit_field
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [15:0] YMIN = 16'(YEAR_MIN);
    localparam logic [15:0] YMAX = 16'(YEAR_MAX);
    localparam logic [1:0] G_TIME = 2'd0, G_DATE = 2'd1;

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_EDIT, S_COMMIT} state_t;

    function automatic logic [7:0] dim(input logic [7:0] m, input logic [15:0] y);
        logic leap;
        leap = ((y % 16'd4) == 16'd0 && (y % 16'd100) != 16'd0) || (y % 16'd400) == 16'd0;
        case (m)
            8'd2:                  dim = leap ? 8'd29 : 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11: dim = 8'd30;
            default:               dim = 8'd31;
        endcase
    endfunction

    state_t state, state_n;
    logic [1:0] group, group_n, field, field_n;
    logic [TW-1:0] tcnt;
    logic [3:0] btn, btn_q, ev;
    logic [7:0] sh0, sh1, dim_sh;
    logic [15:0] sh2, val, lo, hi, stepped;
    logic ev_mode, ev_next, ev_inc, ev_dec, any_ev, timeout, load, step;

    // Edge regs reset high so a button held through reset never fires.
    assign btn = {btn_dec, btn_inc, btn_next, btn_mode};
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q <= '1;
            ev    <= '0;
        end else begin
            btn_q <= btn;
            ev    <= btn & ~btn_q;
        end
    end

    assign ev_mode = ev[0];
    assign ev_next = ev[1];
    assign ev_inc  = ev[2] & ~ev[3];
    assign ev_dec  = ev[3] & ~ev[2];
    assign any_ev  = |ev;
    assign timeout = (tcnt == TW'(TIMEOUT_CYCLES - 1)) && !any_ev;
    assign dim_sh  = dim(sh1, sh2);

    always_comb begin
        state_n = state;
        group_n = group;
        field_n = field;
        load    = 1'b0;
        step    = 1'b0;
        case (state)
            S_IDLE: if (ev_mode) state_n = S_SELECT;
            S_SELECT: begin
                if (ev_mode || timeout) state_n = S_IDLE;
                else if (ev_next) begin
                    state_n = S_EDIT;
                    field_n = 2'd0;
                    load    = 1'b1;
                end
                else if (ev_inc) group_n = (group == 2'd2) ? 2'd0 : group + 2'd1;
                else if (ev_dec) group_n = (group == 2'd0) ? 2'd2 : group - 2'd1;
            end
            S_EDIT: begin
                if (ev_mode || timeout) state_n = S_IDLE;
                else if (ev_next) begin
                    if (field == 2'd2) state_n = S_COMMIT;
                    else field_n = field + 2'd1;
                end
                else if (ev_inc || ev_dec) step = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        if (state_n == S_IDLE) begin
            group_n = 2'd0;
            field_n = 2'd0;
        end
    end

    // Wrap range of the item under edit; the day range follows the shadow month/year.
    always_comb begin
        lo = 16'd0;
        hi = 16'd59;
        case (field)
            2'd0:    val = {8'd0, sh0};
            2'd1:    val = {8'd0, sh1};
            default: val = sh2;
        endcase
        if (group == G_DATE) begin
            case (field)
                2'd0:    begin lo = 16'd1; hi = {8'd0, dim_sh}; end
                2'd1:    begin lo = 16'd1; hi = 16'd12; end
                default: begin lo = YMIN;  hi = YMAX; end
            endcase
        end else if (field == 2'd0) begin
            hi = 16'd23;
        end
        if (ev_inc) stepped = (val >= hi) ? lo : val + 16'd1;
        else        stepped = (val <= lo) ? hi : val - 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            group <= 2'd0;
            field <= 2'd0;
            tcnt  <= '0;
        end else begin
            state <= state_n;
            group <= group_n;
            field <= field_n;
            if (state == S_IDLE || state == S_COMMIT || any_ev) tcnt <= '0;
            else tcnt <= tcnt + TW'(1);
        end
    end

    // Bus and strobe update together on the edge leaving COMMIT, so the bus is stable under the strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh0 <= '0; sh1 <= '0; sh2 <= '0;
            input_hour <= '0; input_min <= '0; input_sec <= '0;
            input_day <= 8'd1; input_month <= 8'd1; input_year <= YMIN;
            alarm_input_hour <= '0; alarm_input_min <= '0; alarm_input_sec <= '0;
            set_time <= 1'b0; set_date <= 1'b0; set_alarm <= 1'b0;
        end else begin
            set_time  <= 1'b0;
            set_date  <= 1'b0;
            set_alarm <= 1'b0;
            if (load) begin
                case (group)
                    G_TIME:  begin sh0 <= cur_hour; sh1 <= cur_min; sh2 <= {8'd0, cur_sec}; end
                    G_DATE:  begin sh0 <= cur_day;  sh1 <= cur_month; sh2 <= cur_year; end
                    default: begin sh0 <= alarm_input_hour; sh1 <= alarm_input_min;
                                   sh2 <= {8'd0, alarm_input_sec}; end
                endcase
            end else if (step) begin
                case (field)
                    2'd0:    sh0 <= stepped[7:0];
                    2'd1:    sh1 <= stepped[7:0];
                    default: sh2 <= stepped;
                endcase
            end
            if (state == S_COMMIT) begin
                case (group)
                    G_TIME: begin
                        input_hour <= sh0; input_min <= sh1; input_sec <= sh2[7:0];
                        set_time <= 1'b1;
                    end
                    G_DATE: begin
                        input_day <= (sh0 > dim_sh) ? dim_sh : sh0;
                        input_month <= sh1; input_year <= sh2;
                        set_date <= 1'b1;
                    end
                    default: begin
                        alarm_input_hour <= sh0; alarm_input_min <= sh1; alarm_input_sec <= sh2[7:0];
                        set_alarm <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign edit_active = (state != S_IDLE);
    assign edit_group  = group;
    assign edit_field  = field;
endmodule

// File: tb/tb_time_entry_ctrl.sv
// Bench for time_entry_ctrl: table of edit sessions plus hand-written abort/timeout/reset sequences.
module tb_time_entry_ctrl;
    logic clk = 1'b0, reset_n = 1'b0;
    logic btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [7:0] cur_hour = '0, cur_min = '0, cur_sec = '0, cur_day = 8'd1, cur_month = 8'd1;
    logic [15:0] cur_year = 16'd2000;
    logic [7:0] input_hour, input_min, input_sec, input_day, input_month;
    logic [15:0] input_year;
    logic [7:0] alarm_input_hour, alarm_input_min, alarm_input_sec;
    logic set_time, set_date, set_alarm, edit_active;
    logic [1:0] edit_group, edit_field;

    time_entry_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .cur_day(cur_day), .cur_month(cur_month), .cur_year(cur_year),
        .input_hour(input_hour), .input_min(input_min), .input_sec(input_sec),
        .input_day(input_day), .input_month(input_month), .input_year(input_year),
        .alarm_input_hour(alarm_input_hour), .alarm_input_min(alarm_input_min),
        .alarm_input_sec(alarm_input_sec),
        .set_time(set_time), .set_date(set_date), .set_alarm(set_alarm),
        .edit_active(edit_active), .edit_group(edit_group), .edit_field(edit_field)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] B_MODE = 4'b0001, B_NEXT = 4'b0010, B_INC = 4'b0100, B_DEC = 4'b1000;

    typedef struct {
        int grp;
        logic [7:0] ca, cb; logic [15:0] cc;
        int d0, d1, d2;
        logic [7:0] ea, eb; logic [15:0] ec;
    } vec_t;
    typedef struct { int grp; logic [31:0] val; } exp_t;

    exp_t sbq[$];
    vec_t vt[14];
    int n_cmp = 0, n_bad = 0;
    int strb_cycles = 0, multi = 0;

    always @(negedge clk) begin
        if (set_time || set_date || set_alarm) strb_cycles++;
        if (int'(set_time) + int'(set_date) + int'(set_alarm) > 1) multi++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] bus(input int g);
        if (g == 0) return {8'd0, input_hour, input_min, input_sec};
        if (g == 1) return {input_day, input_month, input_year};
        return {8'd0, alarm_input_hour, alarm_input_min, alarm_input_sec};
    endfunction

    function automatic logic [31:0] pack(input int g, input logic [7:0] a, input logic [7:0] b,
                                         input logic [15:0] c);
        if (g == 1) return {a, b, c};
        return {8'd0, a, b, c[7:0]};
    endfunction

    task automatic press(input logic [3:0] m);
        @(negedge clk); {btn_dec, btn_inc, btn_next, btn_mode} = m;
        @(negedge clk); {btn_dec, btn_inc, btn_next, btn_mode} = 4'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic bump(input int d);
        if (d > 0) repeat (d) press(B_INC);
        else if (d < 0) repeat (-d) press(B_DEC);
    endtask

    task automatic set_cur(input int g, input logic [7:0] a, input logic [7:0] b, input logic [15:0] c);
        @(negedge clk);
        if (g == 0) begin cur_hour = a; cur_min = b; cur_sec = c[7:0]; end
        else if (g == 1) begin cur_day = a; cur_month = b; cur_year = c; end
    endtask

    task automatic enter(input int g);
        press(B_MODE);
        chk("active after mode", 32'(edit_active), 32'd1);
        if (g == 1) press(B_INC);
        else if (g == 2) press(B_DEC);
        chk("edit_group", 32'(edit_group), 32'(g));
        press(B_NEXT);
        chk("edit_field start", 32'(edit_field), 32'd0);
    endtask

    // Last-field next: strobe must appear at the third sampling point after the press.
    task automatic commit_expect(input string nm, input int g, input logic [31:0] val);
        logic [31:0] others [3];
        int s0, lat;
        exp_t e;
        for (int k = 0; k < 3; k++) others[k] = bus(k);
        s0 = strb_cycles;
        sbq.push_back('{g, val});
        @(negedge clk); btn_next = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) btn_next = 1'b0;
            if (set_time || set_date || set_alarm) begin lat = i; break; end
        end
        chk({nm, " latency"}, 32'(lat), 32'd3);
        e = sbq.pop_front();
        if (lat != 0) begin
            chk({nm, " strobe"}, {29'd0, set_alarm, set_date, set_time}, 32'd1 << e.grp);
            chk({nm, " value"}, bus(e.grp), e.val);
        end
        repeat (3) @(negedge clk);
        chk({nm, " pulse cycles"}, 32'(strb_cycles - s0), 32'd1);
        chk({nm, " idle after"}, 32'(edit_active), 32'd0);
        for (int k = 0; k < 3; k++)
            if (k != g) chk({nm, " other bus kept"}, bus(k), others[k]);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " time bus"}, bus(0), 32'd0);
        chk({nm, " date bus"}, bus(1), {8'd1, 8'd1, 16'd2000});
        chk({nm, " alarm bus"}, bus(2), 32'd0);
        chk({nm, " strobes"}, {29'd0, set_alarm, set_date, set_time}, 32'd0);
        chk({nm, " ctl"}, {27'd0, edit_active, edit_group, edit_field}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap [3];
        int s0;
        //         grp  ca     cb     cc        d0  d1  d2  ea     eb     ec
        vt[0]  = '{2, 8'd0,  8'd0,  16'd0,    -1, -1, -1, 8'd23, 8'd59, 16'd59};
        vt[1]  = '{0, 8'd23, 8'd59, 16'd58,    1,  0,  0, 8'd0,  8'd59, 16'd58};
        vt[2]  = '{0, 8'd0,  8'd0,  16'd0,    -1, -1, -1, 8'd23, 8'd59, 16'd59};
        vt[3]  = '{0, 8'd12, 8'd30, 16'd45,    2, -3, 14, 8'd14, 8'd27, 16'd59};
        vt[4]  = '{0, 8'd10, 8'd59, 16'd59,    0,  1,  1, 8'd10, 8'd0,  16'd0};
        vt[5]  = '{2, 8'd0,  8'd0,  16'd0,     1,  1,  1, 8'd0,  8'd0,  16'd0};
        vt[6]  = '{2, 8'd0,  8'd0,  16'd0,     5, 10,  0, 8'd5,  8'd10, 16'd0};
        vt[7]  = '{1, 8'd28, 8'd2,  16'd2020,  1,  0,  0, 8'd29, 8'd2,  16'd2020};
        vt[8]  = '{1, 8'd31, 8'd12, 16'd2099,  1,  1,  1, 8'd1,  8'd1,  16'd2000};
        vt[9]  = '{1, 8'd1,  8'd1,  16'd2000, -1, -1, -1, 8'd31, 8'd12, 16'd2099};
        vt[10] = '{1, 8'd31, 8'd3,  16'd2023,  0, -1,  0, 8'd28, 8'd2,  16'd2023};
        vt[11] = '{1, 8'd1,  8'd2,  16'd2000, -1,  0,  0, 8'd29, 8'd2,  16'd2000};
        vt[12] = '{1, 8'd30, 8'd4,  16'd2021,  1,  0,  0, 8'd1,  8'd4,  16'd2021};
        vt[13] = '{1, 8'd29, 8'd2,  16'd2024,  0,  0,  1, 8'd28, 8'd2,  16'd2025};

        repeat (3) @(negedge clk);
        chk_reset_vals("in reset");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("after reset");

        foreach (vt[i]) begin
            set_cur(vt[i].grp, vt[i].ca, vt[i].cb, vt[i].cc);
            enter(vt[i].grp);
            bump(vt[i].d0); press(B_NEXT);
            bump(vt[i].d1); press(B_NEXT);
            bump(vt[i].d2);
            commit_expect($sformatf("vec%0d", i), vt[i].grp,
                          pack(vt[i].grp, vt[i].ea, vt[i].eb, vt[i].ec));
        end

        // Leap-day walk, then commit into a non-leap year clamps the day.
        set_cur(1, 8'd28, 8'd2, 16'd2020);
        enter(1);
        press(B_DEC); press(B_INC); press(B_INC);
        press(B_NEXT); press(B_NEXT); press(B_INC);
        commit_expect("leap clamp", 1, pack(1, 8'd28, 8'd2, 16'd2021));

        // Mode mid-edit aborts with no strobe and no bus change.
        for (int k = 0; k < 3; k++) snap[k] = bus(k);
        s0 = strb_cycles;
        set_cur(0, 8'd5, 8'd6, 16'd7);
        enter(0); press(B_INC); press(B_MODE);
        chk("mode abort idle", 32'(edit_active), 32'd0);
        // Mode beats next in the same cycle.
        press(B_MODE); press(B_MODE | B_NEXT);
        chk("mode priority idle", 32'(edit_active), 32'd0);
        // Timeout in SELECT, with an edge in between restarting the count.
        press(B_MODE);
        repeat (20) @(negedge clk);
        chk("select not yet timed out", 32'(edit_active), 32'd1);
        press(B_INC);
        repeat (20) @(negedge clk);
        chk("timeout restarted by edge", 32'(edit_active), 32'd1);
        repeat (15) @(negedge clk);
        chk("select timeout idle", 32'(edit_active), 32'd0);
        enter(0);
        repeat (40) @(negedge clk);
        chk("edit timeout idle", 32'(edit_active), 32'd0);
        chk("no strobe on aborts", 32'(strb_cycles - s0), 32'd0);
        for (int k = 0; k < 3; k++) chk("bus kept on abort", bus(k), snap[k]);

        // inc+dec is a no-op; next+inc advances without touching the value.
        set_cur(0, 8'd7, 8'd8, 16'd9);
        enter(0);
        press(B_INC | B_DEC);
        chk("inc+dec field", 32'(edit_field), 32'd0);
        press(B_NEXT | B_INC);
        chk("next+inc field", 32'(edit_field), 32'd1);
        press(B_INC); press(B_NEXT);
        chk("field 2", 32'(edit_field), 32'd2);
        commit_expect("combo buttons", 0, pack(0, 8'd7, 8'd9, 16'd9));

        // Async reset mid-edit, with mode held through the reset release.
        enter(1); press(B_INC);
        @(negedge clk); reset_n = 1'b0; btn_mode = 1'b1;
        #1;
        chk_reset_vals("async reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("held mode ignored", 32'(edit_active), 32'd0);
        btn_mode = 1'b0;
        press(B_MODE);
        chk("alive after reset", 32'(edit_active), 32'd1);
        press(B_MODE);
        chk("abort after reset", 32'(edit_active), 32'd0);

        chk("one strobe per cycle", 32'(multi), 32'd0);
        chk("scoreboard drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
